seg7_display_monitor: RTL and testbench
=======================================

Name: seg7_display_monitor

Overview:
Receive-side counterpart to the seven-segment seconds counter. Samples a 7-bit segment bus (same encoding our seg7 encoder produces), filters glitches and decodes it back to a BCD digit. Measures the clock-cycle interval between digit changes and flags out-of-sequence digits and illegal patterns. Used on-chip as a self-check loopback of uo_out[6:0], or on ui_in to monitor an external display.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized samples a pattern must hold before it is accepted (legal range 1..15).
CNT_W, 24, width of the period counter and of period_out.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  enable; when 0, all state holds and pulses are 0
seg_in  input  7  segment bus {g,f,e,d,c,b,a}, active high, asynchronous to clk
digit  output  4  last accepted decoded digit 0..9
digit_valid  output  1  1 while the last accepted pattern is a legal digit
change_pulse  output  1  one-cycle pulse on each accepted legal digit
seq_err  output  1  one-cycle pulse: accepted digit is not previous+1 mod 10
bad_pattern  output  1  one-cycle pulse: accepted pattern is non-blank and illegal
period_out  output  CNT_W  cycles between the last two accepted legal digits
period_valid  output  1  period_out holds a real measurement
period_sat  output  1  period_out is saturated (all ones)

Behaviour:
- Reset (rst_n=0, async): every output is 0; synchronizer, candidate, stability count, period counter, and the has-previous flag are cleared. Mid-operation reset takes effect immediately, with no clock required.
- Legal codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. 0x00 is blank. Every other value is illegal.
- Synchronizer: 2 flops on seg_in (s1, s2).
- Filter:
  - cand register plus stab count.
  - If s2 != cand: cand<=s2 and stab<=1.
  - Else stab increments, saturating at STABLE_CYCLES.
  - An accept event fires on the edge where stab reaches STABLE_CYCLES and cand != accepted pattern.
  - A pattern applied before edge 1 and held therefore updates the outputs at edge 2+STABLE_CYCLES.
  - Shorter pulses are ignored.
- Accept, legal digit:
  - digit<=decode, digit_valid<=1, change_pulse<=1.
  - If has-previous=1: seq_err<=1 when digit != (prev==9 ? 0 : prev+1); period_out<=period_cnt, period_valid<=1, period_sat<=(period_cnt==max).
  - Then has-previous<=1 and period_cnt<=1.
- Accept, blank: digit_valid<=0, digit held, has-previous<=0, no pulses.
- Accept, illegal: same as blank, plus bad_pattern<=1.
- After a blank or illegal accept, the next legal digit gets no seq_err and no new period. period_valid keeps its old value.
- period_cnt:
  - Increments every enabled cycle, saturating at 2^CNT_W-1.
  - Loads 1 on a legal accept.
  - Changes every P cycles therefore give period_out=P.
- Pulses are high for exactly one cycle per event. Simultaneous seq_err and change_pulse are expected.
- ena=0: nothing changes and pulses are forced to 0. The synchronizer also holds.

Test Plan:
1. Reset, then hold seg_in=0x3F with STABLE_CYCLES=4 -> at edge 6: digit=0, digit_valid=1, change_pulse high 1 cycle, period_valid=0, seq_err=0.
2. Step codes for 0..9 then 0, each held 100 cycles -> 11 change_pulses. From the 2nd pulse on: period_out=100 and period_valid=1. seq_err never fires, including on the 9->0 wrap.
3. Steady 0x06, then glitch to 0x5B for 3 cycles, then back to 0x06 -> no change_pulse, digit stays 1. Hold 0x5B for 4+ cycles instead -> digit=2, change_pulse.
4. 0x3F accepted, then 0x5B -> digit=2, seq_err and change_pulse in the same cycle.
5. Illegal 0x49 -> bad_pattern pulse, digit_valid=0, digit retained. Then 0x00 -> no pulse. Then 0x06 -> digit=1, no seq_err, period_out unchanged.
6. CNT_W=8, hold 0x06 then 0x5B with 300 cycles between accepts -> period_out=255, period_sat=1. Then assert rst_n=0 between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/seg7_display_monitor.sv
// Seven-segment receive monitor: synchronizes and deglitches a segment bus, decodes it
// to BCD, and measures/validates the digit sequence and the interval between changes.
module seg7_display_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             change_pulse,
  output logic             seq_err,
  output logic             bad_pattern,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             period_sat
);

  localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [6:0]       s1, s2, cand, acc_pat;
  logic [3:0]       stab;
  logic [CNT_W-1:0] period_cnt;
  logic             has_prev;
  logic             chg_q, seq_q, bad_q;
  logic             reach, accept, dec_legal;
  logic [3:0]       dec_digit, next_digit;

  always_comb begin
    dec_legal = 1'b1;
    dec_digit = '0;
    case (s2)
      7'h3F:   dec_digit = 4'd0;
      7'h06:   dec_digit = 4'd1;
      7'h5B:   dec_digit = 4'd2;
      7'h4F:   dec_digit = 4'd3;
      7'h66:   dec_digit = 4'd4;
      7'h6D:   dec_digit = 4'd5;
      7'h7D:   dec_digit = 4'd6;
      7'h07:   dec_digit = 4'd7;
      7'h7F:   dec_digit = 4'd8;
      7'h6F:   dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  // The pattern being accepted is always s2: either it equals cand, or with a one-sample
  // threshold it becomes cand and reaches the threshold on the same edge.
  always_comb begin
    reach      = (s2 != cand) ? (STAB_MAX == 4'd1) : (stab == STAB_MAX - 4'd1);
    accept     = ena && reach && (s2 != acc_pat);
    next_digit = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      cand <= '0;
      stab <= '0;
    end else if (ena) begin
      s1 <= seg_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        stab <= 4'd1;
      end else if (stab != STAB_MAX) begin
        stab <= stab + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_pat      <= '0;
      digit        <= '0;
      digit_valid  <= 1'b0;
      has_prev     <= 1'b0;
      chg_q        <= 1'b0;
      seq_q        <= 1'b0;
      bad_q        <= 1'b0;
      period_cnt   <= '0;
      period_out   <= '0;
      period_valid <= 1'b0;
      period_sat   <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      seq_q <= 1'b0;
      bad_q <= 1'b0;
      if (ena) begin
        if (accept && dec_legal) begin
          period_cnt <= CNT_W'(1);
        end else if (period_cnt != CNT_MAX) begin
          period_cnt <= period_cnt + CNT_W'(1);
        end
      end
      if (accept) begin
        acc_pat <= s2;
        if (dec_legal) begin
          digit       <= dec_digit;
          digit_valid <= 1'b1;
          chg_q       <= 1'b1;
          has_prev    <= 1'b1;
          if (has_prev) begin
            seq_q        <= (dec_digit != next_digit);
            period_out   <= period_cnt;
            period_valid <= 1'b1;
            period_sat   <= (period_cnt == CNT_MAX);
          end
        end else begin
          digit_valid <= 1'b0;
          has_prev    <= 1'b0;
          bad_q       <= (s2 != 7'h00);
        end
      end
    end
  end

  // Gating keeps a pulse registered just before ena drops from showing while disabled.
  assign change_pulse = chg_q & ena;
  assign seq_err      = seq_q & ena;
  assign bad_pattern  = bad_q & ena;

endmodule

// File: tb/tb_seg7_display_monitor.sv
// Bench for seg7_display_monitor: directed phases plus randomized segment streams, checked
// each cycle against a history-based reference model; two instances (24-bit and 8-bit period).
module tb_seg7_display_monitor;

  localparam int S = 4;
  localparam logic [6:0] CODES [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst_n, ena;
  logic [6:0]  seg_in;

  logic [3:0]  a_digit, b_digit;
  logic        a_dv, a_chg, a_seq, a_bad, a_pv, a_sat;
  logic        b_dv, b_chg, b_seq, b_bad, b_pv, b_sat;
  logic [23:0] a_per;
  logic [7:0]  b_per;

  int n_cmp = 0;
  int n_err = 0;

  seg7_display_monitor #(.STABLE_CYCLES(S), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in),
    .digit(a_digit), .digit_valid(a_dv), .change_pulse(a_chg), .seq_err(a_seq),
    .bad_pattern(a_bad), .period_out(a_per), .period_valid(a_pv), .period_sat(a_sat));

  seg7_display_monitor #(.STABLE_CYCLES(S), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_in(seg_in),
    .digit(b_digit), .digit_valid(b_dv), .change_pulse(b_chg), .seq_err(b_seq),
    .bad_pattern(b_bad), .period_out(b_per), .period_valid(b_pv), .period_sat(b_sat));

  always #5 clk = ~clk;

  // Reference model: history of samples taken on enabled edges since reset.
  logic [6:0] hist[$];
  int  nidx, m_digit, m_last, m_raw;
  bit  m_dv, m_chg, m_seq, m_bad, m_pv, m_has_prev;
  logic [6:0] m_acc;

  int w_chg, w_seq, w_bad, w_both;

  function automatic int decode(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (CODES[i] == p) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    nidx = 0; m_digit = 0; m_last = 0; m_raw = 0;
    m_dv = 0; m_chg = 0; m_seq = 0; m_bad = 0; m_pv = 0; m_has_prev = 0;
    m_acc = '0;
  endtask

  // A pattern is accepted on the edge where its run of samples (seen through the 2-flop
  // delay) first becomes S long, provided it differs from the last accepted pattern.
  task automatic model_edge(input logic [6:0] seg, input logic en);
    int n, d;
    logic [6:0] x;
    bit fresh;
    m_chg = 0; m_seq = 0; m_bad = 0;
    if (!en) return;
    hist.push_back(seg);
    nidx++;
    n = nidx;
    if (n >= S + 2) begin
      x = hist[n-3];
      fresh = 1;
      for (int k = 1; k < S; k++) if (hist[n-3-k] != x) fresh = 0;
      if (n - 3 - S >= 0 && hist[n-3-S] == x) fresh = 0;
      if (fresh && x != m_acc) begin
        m_acc = x;
        d = decode(x);
        if (d >= 0) begin
          if (m_has_prev) begin
            m_seq = (d != (m_digit + 1) % 10);
            m_raw = n - m_last;
            m_pv  = 1;
          end
          m_digit = d; m_dv = 1; m_chg = 1; m_has_prev = 1; m_last = n;
        end else begin
          m_dv = 0; m_has_prev = 0; m_bad = (x != 7'h00);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.digit",  32'(a_digit), 32'(m_digit));
    chk("a.dv",     32'(a_dv),    32'(m_dv));
    chk("a.chg",    32'(a_chg),   32'(m_chg));
    chk("a.seq",    32'(a_seq),   32'(m_seq));
    chk("a.bad",    32'(a_bad),   32'(m_bad));
    chk("a.period", 32'(a_per),   (m_raw >= 32'hFFFFFF) ? 32'hFFFFFF : 32'(m_raw));
    chk("a.pv",     32'(a_pv),    32'(m_pv));
    chk("a.sat",    32'(a_sat),   32'(m_raw >= 32'hFFFFFF));
    chk("b.digit",  32'(b_digit), 32'(m_digit));
    chk("b.dv",     32'(b_dv),    32'(m_dv));
    chk("b.chg",    32'(b_chg),   32'(m_chg));
    chk("b.seq",    32'(b_seq),   32'(m_seq));
    chk("b.bad",    32'(b_bad),   32'(m_bad));
    chk("b.period", 32'(b_per),   (m_raw >= 255) ? 32'd255 : 32'(m_raw));
    chk("b.pv",     32'(b_pv),    32'(m_pv));
    chk("b.sat",    32'(b_sat),   32'(m_raw >= 255));
  endtask

  task automatic step(input logic [6:0] seg, input logic en);
    seg_in = seg;
    ena    = en;
    @(posedge clk);
    model_edge(seg, en);
    #1;
    check_all();
    w_chg  += int'(a_chg);
    w_seq  += int'(a_seq);
    w_bad  += int'(a_bad);
    w_both += int'(a_chg & a_seq);
  endtask

  task automatic hold(input logic [6:0] seg, input int cycles);
    repeat (cycles) step(seg, 1'b1);
  endtask

  task automatic clear_window();
    w_chg = 0; w_seq = 0; w_bad = 0; w_both = 0;
  endtask

  initial begin
    logic [6:0] code;
    int sel, len;
    rst_n = 1'b0; ena = 1'b0; seg_in = 7'h3F;
    model_reset();
    clear_window();
    #2 check_all();
    #10 rst_n = 1'b1;

    // Pattern held from before edge 1 is accepted on edge 2+S.
    repeat (S + 1) step(7'h3F, 1'b1);
    chk("p1.chg_early", 32'(a_chg), 32'd0);
    step(7'h3F, 1'b1);
    chk("p1.chg", 32'(a_chg), 32'd1);
    chk("p1.digit", 32'(a_digit), 32'd0);
    chk("p1.dv", 32'(a_dv), 32'd1);
    chk("p1.pv", 32'(a_pv), 32'd0);
    chk("p1.seq", 32'(a_seq), 32'd0);
    hold(7'h3F, 4);

    // Count 0..9 then wrap to 0, each held 100 cycles.
    hold(7'h00, 10);
    clear_window();
    for (int d = 0; d <= 10; d++) hold(CODES[d % 10], 100);
    chk("p2.pulses", 32'(w_chg), 32'd11);
    chk("p2.seqerr", 32'(w_seq), 32'd0);
    chk("p2.period", 32'(a_per), 32'd100);
    chk("p2.pv", 32'(a_pv), 32'd1);

    // Short glitch ignored, sustained change accepted.
    hold(7'h06, 20);
    clear_window();
    hold(7'h5B, 3);
    hold(7'h06, 20);
    chk("p3.glitch_chg", 32'(w_chg), 32'd0);
    chk("p3.glitch_digit", 32'(a_digit), 32'd1);
    clear_window();
    hold(7'h5B, 20);
    chk("p3.chg", 32'(w_chg), 32'd1);
    chk("p3.digit", 32'(a_digit), 32'd2);

    // 0 followed by 2: sequence error coincident with the change pulse.
    hold(7'h3F, 20);
    clear_window();
    hold(7'h5B, 20);
    chk("p4.chg", 32'(w_chg), 32'd1);
    chk("p4.seq", 32'(w_seq), 32'd1);
    chk("p4.both", 32'(w_both), 32'd1);
    chk("p4.period", 32'(a_per), 32'd20);

    // Illegal, blank, then a legal digit with no sequence check and no new period.
    clear_window();
    hold(7'h49, 20);
    chk("p5.bad", 32'(w_bad), 32'd1);
    chk("p5.bad_dv", 32'(a_dv), 32'd0);
    chk("p5.bad_digit", 32'(a_digit), 32'd2);
    clear_window();
    hold(7'h00, 20);
    chk("p5.blank_bad", 32'(w_bad), 32'd0);
    chk("p5.blank_chg", 32'(w_chg), 32'd0);
    clear_window();
    hold(7'h06, 20);
    chk("p5.digit", 32'(a_digit), 32'd1);
    chk("p5.chg", 32'(w_chg), 32'd1);
    chk("p5.seq", 32'(w_seq), 32'd0);
    chk("p5.period", 32'(a_per), 32'd20);
    chk("p5.pv", 32'(a_pv), 32'd1);

    // Randomized segment streams with ena dropouts.
    for (int seg_i = 0; seg_i < 150; seg_i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 60)      code = CODES[(m_digit + 1) % 10];
      else if (sel < 75) code = CODES[$urandom_range(0, 9)];
      else if (sel < 85) code = 7'h00;
      else begin
        code = 7'($urandom_range(1, 127));
        while (decode(code) >= 0) code = 7'($urandom_range(1, 127));
      end
      len = (sel >= 95) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 12));
      repeat (len) step(code, 1'($urandom_range(0, 7) != 0));
    end

    // Long interval: saturates the 8-bit period, not the 24-bit one.
    hold(7'h00, 20);
    hold(7'h06, 300);
    hold(7'h5B, 20);
    chk("p6.b_period", 32'(b_per), 32'd255);
    chk("p6.b_sat", 32'(b_sat), 32'd1);
    chk("p6.a_period", 32'(a_per), 32'd300);
    chk("p6.a_sat", 32'(a_sat), 32'd0);

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    hold(7'h06, 10);
    chk("p6.post_digit", 32'(a_digit), 32'd1);
    chk("p6.post_pv", 32'(a_pv), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
